// File: rtl/mult8_rev_pkg.sv
// -----------------------------------------------------------------------------
// mult8_rev_pkg
// Shared types for the reversible-multiplier history buffer:
//   state_t       - direction FSM states (FWD, F2R, REV, R2F)
//   entry_t       - one history entry {product p[15:0], operand a[7:0]}
//   DEPTH_DEFAULT - default number of history entries
//   mul8()        - 8x8 -> 16-bit product used by the optional consistency check
// -----------------------------------------------------------------------------
package mult8_rev_pkg;

    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        FWD = 2'd0,
        F2R = 2'd1,
        REV = 2'd2,
        R2F = 2'd3
    } state_t;

    typedef struct packed {
        logic [15:0] p;
        logic [7:0]  a;
    } entry_t;

    function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
        return 16'(x) * 16'(y);
    endfunction

endpackage

// File: rtl/mult8_rev_lifo.sv
// -----------------------------------------------------------------------------
// mult8_rev_lifo
// LIFO storage with a single occupancy pointer. Push writes at the current
// level and increments it; pop decrements it. top always shows the most
// recently pushed entry (undefined content while empty). Storage itself is
// not reset; only the pointer is.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   push, push_data   - write request and data (ignored when full)
//   pop               - remove top entry (ignored when empty)
//   top               - current top entry
//   level, full, empty- occupancy status
// -----------------------------------------------------------------------------
module mult8_rev_lifo
    import mult8_rev_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     top,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_r [DEPTH];
    logic [LW-1:0]   level_r;
    logic [AW-1:0]   wr_idx_s;
    logic [AW-1:0]   top_idx_s;
    logic            do_push_s;
    logic            do_pop_s;

    assign wr_idx_s  = AW'(level_r);
    assign top_idx_s = AW'(level_r - LW'(1));
    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == LW'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign top       = mem_r[top_idx_s];
    assign level     = level_r;

    // Entry storage: written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

    // Occupancy pointer; push and pop are mutually exclusive at the top level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= LW'(0);
        end else if (do_push_s && !do_pop_s) begin
            level_r <= level_r + LW'(1);
        end else if (do_pop_s && !do_push_s) begin
            level_r <= level_r - LW'(1);
        end
    end

endmodule

// File: rtl/mult8_rev_hist_buf.sv
// -----------------------------------------------------------------------------
// mult8_rev_hist_buf
// History buffer for a reversible 8-bit multiplier. In forward mode each
// {product, A} tuple from the multiplier is pushed onto a LIFO and the product
// is forwarded downstream. In reverse mode the history is popped in strict
// reverse order and handed back to the multiplier. The F2R / R2F states only
// drain the respective output register before the direction flips.
// Optional feature (macro MULT8_REV_CHECK_EN): compares the operands recovered
// by the multiplier against the last reverse tuple handed over, sticky err.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   dir                                - requested direction (0 fwd, 1 rev)
//   in_valid/in_ready/in_p/in_a        - forward tuple from multiplier
//   out_valid/out_ready/out_p          - forward product to consumer
//   rev_valid/rev_ready/rev_p/rev_a    - reverse tuple to multiplier
//   chk_valid/chk_a/chk_b              - recovered operands from multiplier
//   level, mode_rev, err               - occupancy, direction, sticky error
// -----------------------------------------------------------------------------
module mult8_rev_hist_buf
    import mult8_rev_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dir,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_p,
    input  logic [7:0]                 in_a,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_p,
    output logic                       rev_valid,
    input  logic                       rev_ready,
    output logic [15:0]                rev_p,
    output logic [7:0]                 rev_a,
    input  logic                       chk_valid,
    input  logic [7:0]                 chk_a,
    input  logic [7:0]                 chk_b,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       mode_rev,
    output logic                       err
);

    state_t state_r;
    entry_t top_s;
    entry_t push_data_s;
    logic   full_s;
    logic   empty_s;
    logic   push_s;
    logic   pop_s;

    assign in_ready    = (state_r == FWD) && !full_s && (!out_valid || out_ready);
    assign push_s      = in_valid && in_ready;
    assign pop_s       = (state_r == REV) && !empty_s && (!rev_valid || rev_ready);
    assign push_data_s = '{p: in_p, a: in_a};

    mult8_rev_lifo #(
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .top       (top_s),
        .level     (level),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Direction FSM; transitional states wait for their output register to drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FWD;
            mode_rev <= 1'b0;
        end else begin
            case (state_r)
                FWD: if (dir)        begin state_r <= F2R; end
                F2R: if (!out_valid) begin state_r <= REV; mode_rev <= 1'b1; end
                REV: if (!dir)       begin state_r <= R2F; end
                R2F: if (!rev_valid) begin state_r <= FWD; mode_rev <= 1'b0; end
                default: begin
                    state_r  <= FWD;
                    mode_rev <= 1'b0;
                end
            endcase
        end
    end

    // Forward output register: load on push, clear when consumed without a new push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= 16'h0000;
        end else if (push_s) begin
            out_valid <= 1'b1;
            out_p     <= in_p;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Reverse output register: load on pop, clear when consumed with nothing to pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_valid <= 1'b0;
            rev_p     <= 16'h0000;
            rev_a     <= 8'h00;
        end else if (pop_s) begin
            rev_valid <= 1'b1;
            rev_p     <= top_s.p;
            rev_a     <= top_s.a;
        end else if (rev_ready) begin
            rev_valid <= 1'b0;
        end
    end

`ifdef MULT8_REV_CHECK_EN
    logic [15:0] last_p_r;
    logic [7:0]  last_a_r;

    // Remember the tuple of the most recent completed reverse handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_p_r <= 16'h0000;
            last_a_r <= 8'h00;
        end else if (rev_valid && rev_ready) begin
            last_p_r <= rev_p;
            last_a_r <= rev_a;
        end
    end

    // Sticky error when recovered operands disagree with the handed-back tuple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (chk_valid &&
                     ((chk_a != last_a_r) || (mul8(chk_a, chk_b) != last_p_r))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_chk_s;
    assign unused_chk_s = &{1'b0, chk_valid, chk_a, chk_b};
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mult8_rev_hist_buf.sv
// -----------------------------------------------------------------------------
// tb_mult8_rev_hist_buf
// Directed self-checking bench for mult8_rev_hist_buf (DEPTH = 8). The err
// expectations follow the MULT8_REV_CHECK_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_mult8_rev_hist_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dir;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_p;
    logic [7:0]  in_a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        rev_valid;
    logic        rev_ready;
    logic [15:0] rev_p;
    logic [7:0]  rev_a;
    logic        chk_valid;
    logic [7:0]  chk_a;
    logic [7:0]  chk_b;
    logic [3:0]  level;
    logic        mode_rev;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

`ifdef MULT8_REV_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    mult8_rev_hist_buf #(.DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir       (dir),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .rev_valid (rev_valid),
        .rev_ready (rev_ready),
        .rev_p     (rev_p),
        .rev_a     (rev_a),
        .chk_valid (chk_valid),
        .chk_a     (chk_a),
        .chk_b     (chk_b),
        .level     (level),
        .mode_rev  (mode_rev),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; dir = 1'b0; in_valid = 1'b0; in_p = 16'h0000; in_a = 8'h00;
        out_ready = 1'b0; rev_ready = 1'b0; chk_valid = 1'b0; chk_a = 8'h00; chk_b = 8'h00;
        #12;
        // Reset state
        check("rst_level",     32'(level),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p",     32'(out_p),     32'h0);
        check("rst_rev_valid", 32'(rev_valid), 32'd0);
        check("rst_mode_rev",  32'(mode_rev),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        step();
        rst_n = 1'b1;

        // Forward push, latency 1
        in_valid = 1'b1; in_p = 16'h0048; in_a = 8'h12; out_ready = 1'b1;
        step();
        check("fwd1_out_valid", 32'(out_valid), 32'd1);
        check("fwd1_out_p",     32'(out_p),     32'h0048);
        check("fwd1_level",     32'(level),     32'd1);
        in_p = 16'h0088; in_a = 8'h08;
        step();
        check("fwd2_out_p",  32'(out_p), 32'h0088);
        check("fwd2_level",  32'(level), 32'd2);
        in_valid = 1'b0;
        step();
        check("fwd_drain_out_valid", 32'(out_valid), 32'd0);

        // Turn to reverse and pop both entries in reverse order
        dir = 1'b1; rev_ready = 1'b1;
        step();
        check("f2r_mode_rev", 32'(mode_rev), 32'd0);
        check("f2r_in_ready", 32'(in_ready), 32'd0);
        step();
        check("rev_mode_rev",  32'(mode_rev),  32'd1);
        check("rev_level2",    32'(level),     32'd2);
        check("rev_valid_pre", 32'(rev_valid), 32'd0);
        step();
        check("pop1_valid", 32'(rev_valid), 32'd1);
        check("pop1_p",     32'(rev_p),     32'h0088);
        check("pop1_a",     32'(rev_a),     32'h08);
        check("pop1_level", 32'(level),     32'd1);
        step();
        check("pop2_p",     32'(rev_p), 32'h0048);
        check("pop2_a",     32'(rev_a), 32'h12);
        check("pop2_level", 32'(level), 32'd0);
        step();
        check("pop_end_valid", 32'(rev_valid), 32'd0);
        check("pop_end_level", 32'(level),     32'd0);

        // Operand consistency check: 0x12 * 0x04 = 0x0048 is good, 0x05 is not
        chk_valid = 1'b1; chk_a = 8'h12; chk_b = 8'h04;
        step();
        check("chk_good_err", 32'(err), 32'd0);
        chk_b = 8'h05;
        step();
        check("chk_bad_err", 32'(err), 32'(ERR_EXP));
        chk_valid = 1'b0;
        step();
        check("chk_sticky_err", 32'(err), 32'(ERR_EXP));

        // Back to forward through R2F
        dir = 1'b0;
        step();
        check("r2f_mode_rev", 32'(mode_rev), 32'd1);
        step();
        check("fwd_again_mode_rev", 32'(mode_rev), 32'd0);
        check("fwd_again_in_ready", 32'(in_ready), 32'd1);

        // Fill to DEPTH; a 9th tuple must not be accepted
        reset_pulse();
        check("rst2_err", 32'(err), 32'd0);
        rev_ready = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_p = 16'h1000 + 16'(i);
            in_a = 8'h10 + 8'(i);
            step();
        end
        check("full_level",    32'(level),    32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_p",    32'(out_p),    32'h1008);
        in_p = 16'hBEEF; in_a = 8'hEE;
        step();
        check("ninth_level",     32'(level),     32'd8);
        check("ninth_out_p",     32'(out_p),     32'h1008);
        check("ninth_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // F2R holds while out_valid is stalled; no pop until drained
        reset_pulse();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_p = 16'h2000 + 16'(k);
            in_a = 8'h20 + 8'(k);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0; dir = 1'b1; rev_ready = 1'b0;
        step();
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_p",     32'(out_p),     32'h2004);
        step();
        check("stall_mode_rev",  32'(mode_rev),  32'd0);
        check("stall_level",     32'(level),     32'd4);
        check("stall_rev_valid", 32'(rev_valid), 32'd0);
        out_ready = 1'b1;
        step();
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_in_ready",  32'(in_ready),  32'd0);
        check("drain_mode_rev",  32'(mode_rev),  32'd0);
        step();
        check("rev3_mode_rev",  32'(mode_rev),  32'd1);
        check("rev3_rev_valid", 32'(rev_valid), 32'd0);
        step();
        check("rev3_pop_valid", 32'(rev_valid), 32'd1);
        check("rev3_pop_p",     32'(rev_p),     32'h2004);
        check("rev3_pop_a",     32'(rev_a),     32'h24);
        check("rev3_level",     32'(level),     32'd3);
        step();
        check("rev3_hold_p",     32'(rev_p),     32'h2004);
        check("rev3_hold_level", 32'(level),     32'd3);
        check("rev3_hold_valid", 32'(rev_valid), 32'd1);

        // Asynchronous reset in REV with level 3
        rst_n = 1'b0;
        #1;
        check("arst_level",     32'(level),     32'd0);
        check("arst_rev_valid", 32'(rev_valid), 32'd0);
        check("arst_rev_p",     32'(rev_p),     32'h0);
        check("arst_rev_a",     32'(rev_a),     32'h0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_p",     32'(out_p),     32'h0);
        check("arst_mode_rev",  32'(mode_rev),  32'd0);
        check("arst_err",       32'(err),       32'd0);
        dir = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_level",    32'(level),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult8_rev_hist_buf.md
MULT8_REV_HIST_BUF -- requirements
Module: mult8_rev_hist_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of {product, A} history entries.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port dir, input, 1: requested direction, 0 forward, 1 reverse.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_p (input, 16), in_a (input, 8): forward tuple from multiplier (product f_p, pass-through A f_b0_r_b).
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_p (output, 16): forward product to downstream consumer.
REQ-007 SHALL have ports rev_valid (output, 1), rev_ready (input, 1), rev_p (output, 16), rev_a (output, 8): reverse tuple to multiplier r_p / r_b0_r_b.
REQ-008 SHALL have ports chk_valid (input, 1), chk_a (input, 8), chk_b (input, 8): recovered operands from multiplier r_a / r_b.
REQ-009 SHALL have ports level (output, $clog2(DEPTH+1)), mode_rev (output, 1), err (output, 1): occupancy, active direction, sticky check error.

Function
REQ-010 SHALL implement FSM states FWD, F2R, REV, R2F; mode_rev=1 in REV and R2F.
REQ-011 FWD: dir=1 -> F2R; F2R: out_valid=0 -> REV; REV: dir=0 -> R2F; R2F: rev_valid=0 -> FWD.
REQ-012 SHALL drive in_ready = (state==FWD) && level<DEPTH && (!out_valid || out_ready).
REQ-013 On in_valid&&in_ready SHALL push {in_p,in_a} onto LIFO top, increment level, load out_p=in_p, assert out_valid next cycle (latency 1).
REQ-014 out_valid SHALL hold, out_p stable, until out_ready; out_ready with no push clears out_valid; simultaneous pop and push sustains 1 tuple/cycle.
REQ-015 In REV, when level>0 and (!rev_valid || rev_ready), SHALL pop top entry into rev_p/rev_a, decrement level, assert rev_valid next cycle.
REQ-016 rev_valid SHALL hold, rev_p/rev_a stable, until rev_ready; handshake with level=0 clears rev_valid.
REQ-017 Pops SHALL return entries in strict reverse push order.
REQ-018 level=DEPTH: in_ready=0, no overwrite; level=0 in REV: no pop, rev_valid falls after last handshake.
REQ-019 SHALL issue no push outside FWD and no pop outside REV; F2R/R2F only drain output registers.
REQ-020 dir toggling during F2R/R2F SHALL not abort drain; a new transition is evaluated only after reaching FWD/REV.

Reset
REQ-021 rst_n low SHALL asynchronously force state=FWD, level=0, out_valid=0, out_p=0, rev_valid=0, rev_p=0, rev_a=0, err=0.
REQ-022 Reset mid-operation SHALL discard all history; LIFO storage contents need no reset.

Configuration
REQ-023 With MULT8_REV_CHECK_EN defined, on chk_valid SHALL compare chk_a against A of last completed rev handshake and chk_a*chk_b (16-bit) against its product; mismatch sets err until reset.
REQ-024 Without MULT8_REV_CHECK_EN, chk_* SHALL be ignored and err tied 0; ports remain present.

Structure
REQ-025 Package mult8_rev_pkg SHALL hold state enum, entry struct {p[15:0], a[7:0]}, DEPTH default constant.
REQ-026 LIFO storage and pointer SHALL be sub-module mult8_rev_lifo (push, pop, top, level, full, empty).

Verification
REQ-027 Reset, then push (0x0048,0x12) with out_ready=1 -> out_valid,out_p=0x0048 one cycle later, level=1.
REQ-028 Push (0x0048,0x12),(0x0088,0x08), dir=1, rev_ready=1 -> rev tuples (0x0088,0x08) then (0x0048,0x12), level 2->0, rev_valid falls.
REQ-029 DEPTH=8, push 8 entries, out_ready=1 -> in_ready=0 at level=8, 9th tuple not accepted.
REQ-030 out_ready=0 with out_valid=1, dir=1 -> state holds F2R, no pop until out_ready=1 drains.
REQ-031 CHECK_EN: after rev tuple (0x0048,0x12), chk_a=0x12, chk_b=0x04 -> err=0; chk_b=0x05 -> err=1 sticky.
REQ-032 rst_n low in REV with level=3 -> all outputs zero immediately, state FWD, level=0.
